// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared widths, ALU operation codes and the EX register bundle
// for the nRISC 8-bit datapath.
package nrisc_pkg;

  localparam int DATA_W  = 8;
  localparam int REG_AW  = 2;
  localparam int CTRL_W  = 3;
  localparam int SHAMT_W = 3;

  typedef logic [CTRL_W-1:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD  = 3'd0;
  localparam alu_ctrl_t ALU_SUB  = 3'd1;
  localparam alu_ctrl_t ALU_AND  = 3'd2;
  localparam alu_ctrl_t ALU_OR   = 3'd3;
  localparam alu_ctrl_t ALU_XOR  = 3'd4;
  localparam alu_ctrl_t ALU_SLL  = 3'd5;
  localparam alu_ctrl_t ALU_SRL  = 3'd6;
  localparam alu_ctrl_t ALU_PASS = 3'd7;

  typedef struct packed {
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    alu_ctrl_t          ctrl;
    logic [SHAMT_W-1:0] shamt;
    logic [REG_AW-1:0]  rd;
    logic               wr_en;
  } ex_bundle_t;

endpackage

// File: rtl/ex_fwd_mux.sv
// ex_fwd_mux: source selection for one operand. EX result beats WB result,
// which beats register-file data; hit flags are exported for hazard detection.
module ex_fwd_mux
  import nrisc_pkg::*;
#(
  parameter logic P_FWD_EN = 1'b1
) (
  input  logic [REG_AW-1:0] i_addr,
  input  logic [DATA_W-1:0] i_reg_data,
  input  logic              i_ex_wr,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic [DATA_W-1:0] i_ex_data,
  input  logic              i_wb_wr,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_ex_hit,
  output logic              o_wb_hit
);

  assign o_ex_hit = i_ex_wr && (i_ex_rd == i_addr);
  assign o_wb_hit = i_wb_wr && (i_wb_rd == i_addr);

  // Priority select: youngest in-flight producer wins
  always_comb begin
    o_data = i_reg_data;
    if (P_FWD_EN && o_ex_hit) begin
      o_data = i_ex_data;
    end else if (P_FWD_EN && o_wb_hit) begin
      o_data = i_wb_data;
    end else begin
      o_data = i_reg_data;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: EX register feeding the ALU and WB register capturing its result,
// valid/ready on both sides. Macro EX_FORWARDING_EN enables operand forwarding.
module ex_stage
  import nrisc_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [REG_AW-1:0]  in_rs_addr,
  input  logic [REG_AW-1:0]  in_rt_addr,
  input  logic [DATA_W-1:0]  in_rs_data,
  input  logic [DATA_W-1:0]  in_rt_data,
  input  logic [DATA_W-1:0]  in_imm,
  input  logic               in_use_imm,
  input  logic [CTRL_W-1:0]  in_ALUcontrol,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [REG_AW-1:0]  in_rd_addr,
  input  logic               in_wr_en,
  output logic [CTRL_W-1:0]  ALUcontrol,
  output logic [DATA_W-1:0]  a,
  output logic [DATA_W-1:0]  b,
  output logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  ALUout,
  input  logic               zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic               out_zero,
  output logic [REG_AW-1:0]  out_rd_addr,
  output logic               out_wr_en
);

`ifdef EX_FORWARDING_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  ex_bundle_t          r_ex;
  logic                r_ex_valid;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_result;
  logic                r_out_zero;
  logic [REG_AW-1:0]   r_out_rd_addr;
  logic                r_out_wr_en;

  ex_bundle_t          w_ex_next;
  logic [DATA_W-1:0]   w_rs_data;
  logic [DATA_W-1:0]   w_rt_data;
  logic                w_rs_ex_hit;
  logic                w_rs_wb_hit;
  logic                w_rt_ex_hit;
  logic                w_rt_wb_hit;
  logic                w_ex_wr;
  logic                w_wb_wr;
  logic                w_wb_adv;
  logic                w_slot_free;
  logic                w_hazard;
  logic                w_accept;

  assign w_ex_wr     = r_ex_valid && r_ex.wr_en;
  assign w_wb_wr     = r_out_valid && r_out_wr_en;
  assign w_wb_adv    = r_ex_valid && (!r_out_valid || out_ready);
  assign w_slot_free = !r_ex_valid || w_wb_adv;
  // Without forwarding, any read of an in-flight destination must wait it out
  assign w_hazard    = w_rs_ex_hit || w_rs_wb_hit ||
                       (!in_use_imm && (w_rt_ex_hit || w_rt_wb_hit));
  assign in_ready    = w_slot_free && (FWD_EN || !w_hazard);
  assign w_accept    = in_valid && in_ready && !flush;

  ex_fwd_mux #(.P_FWD_EN(FWD_EN)) u_fwd_rs (
    .i_addr     (in_rs_addr),
    .i_reg_data (in_rs_data),
    .i_ex_wr    (w_ex_wr),
    .i_ex_rd    (r_ex.rd),
    .i_ex_data  (ALUout),
    .i_wb_wr    (w_wb_wr),
    .i_wb_rd    (r_out_rd_addr),
    .i_wb_data  (r_out_result),
    .o_data     (w_rs_data),
    .o_ex_hit   (w_rs_ex_hit),
    .o_wb_hit   (w_rs_wb_hit)
  );

  ex_fwd_mux #(.P_FWD_EN(FWD_EN)) u_fwd_rt (
    .i_addr     (in_rt_addr),
    .i_reg_data (in_rt_data),
    .i_ex_wr    (w_ex_wr),
    .i_ex_rd    (r_ex.rd),
    .i_ex_data  (ALUout),
    .i_wb_wr    (w_wb_wr),
    .i_wb_rd    (r_out_rd_addr),
    .i_wb_data  (r_out_result),
    .o_data     (w_rt_data),
    .o_ex_hit   (w_rt_ex_hit),
    .o_wb_hit   (w_rt_wb_hit)
  );

  // Assemble the next EX contents from the offered instruction
  always_comb begin
    w_ex_next       = r_ex;
    w_ex_next.a     = w_rs_data;
    w_ex_next.ctrl  = alu_ctrl_t'(in_ALUcontrol);
    w_ex_next.shamt = in_shamt;
    w_ex_next.rd    = in_rd_addr;
    w_ex_next.wr_en = in_wr_en;
    if (in_use_imm) begin
      w_ex_next.b = in_imm;
    end else begin
      w_ex_next.b = w_rt_data;
    end
  end

  // EX register: flush beats accept, accept beats drain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ex       <= '0;
      r_ex_valid <= 1'b0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_accept) begin
      r_ex       <= w_ex_next;
      r_ex_valid <= 1'b1;
    end else if (w_wb_adv) begin
      r_ex_valid <= 1'b0;
    end else begin
      r_ex_valid <= r_ex_valid;
    end
  end

  // WB register: captures the ALU result when EX advances
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid   <= 1'b0;
      r_out_result  <= {DATA_W{1'b0}};
      r_out_zero    <= 1'b0;
      r_out_rd_addr <= {REG_AW{1'b0}};
      r_out_wr_en   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_wb_adv) begin
      r_out_valid   <= 1'b1;
      r_out_result  <= ALUout;
      r_out_zero    <= zero;
      r_out_rd_addr <= r_ex.rd;
      r_out_wr_en   <= r_ex.wr_en;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign a           = r_ex.a;
  assign b           = r_ex.b;
  assign ALUcontrol  = r_ex.ctrl;
  assign shamt       = r_ex.shamt;
  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_zero    = r_out_zero;
  assign out_rd_addr = r_out_rd_addr;
  assign out_wr_en   = r_out_wr_en;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors with a queue scoreboard; operand and result
// expectations are pushed at issue and popped by an independent monitor.
module tb_ex_stage;
  import nrisc_pkg::*;

`ifdef EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic               clock = 1'b0;
  logic               reset, flush, in_valid, in_ready, in_use_imm, in_wr_en;
  logic [REG_AW-1:0]  in_rs_addr, in_rt_addr, in_rd_addr, out_rd_addr;
  logic [DATA_W-1:0]  in_rs_data, in_rt_data, in_imm, a, b, out_result;
  logic [CTRL_W-1:0]  in_ALUcontrol, alu_ctrl;
  logic [SHAMT_W-1:0] in_shamt, shamt;
  logic [DATA_W-1:0]  alu_y;
  logic               alu_z, out_valid, out_ready, out_zero, out_wr_en;

  typedef struct { logic [7:0] a; logic [7:0] b; logic [2:0] ctrl; logic [2:0] sh; } op_exp_t;
  typedef struct { logic [7:0] res; logic zero; logic [1:0] rd; logic wr; } res_exp_t;
  op_exp_t  op_q[$];
  res_exp_t res_q[$];
  int checks = 0;
  int errors = 0;
  int stalls;

  always #5 clock = ~clock;

  ex_stage dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_ALUcontrol(in_ALUcontrol), .in_shamt(in_shamt),
    .in_rd_addr(in_rd_addr), .in_wr_en(in_wr_en),
    .ALUcontrol(alu_ctrl), .a(a), .b(b), .shamt(shamt),
    .ALUout(alu_y), .zero(alu_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero),
    .out_rd_addr(out_rd_addr), .out_wr_en(out_wr_en)
  );

  // Behavioural ALU sitting between the stage's two registers
  always_comb begin
    case (alu_ctrl)
      ALU_ADD: alu_y = a + b;
      ALU_SUB: alu_y = a - b;
      ALU_AND: alu_y = a & b;
      ALU_OR:  alu_y = a | b;
      ALU_XOR: alu_y = a ^ b;
      ALU_SLL: alu_y = a << shamt;
      ALU_SRL: alu_y = a >> shamt;
      default: alu_y = b;
    endcase
  end
  assign alu_z = (alu_y == 8'h00);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic offer(input logic [1:0] rs, input logic [1:0] rt,
                       input logic [7:0] rsd, input logic [7:0] rtd,
                       input logic [7:0] imm, input logic ui,
                       input logic [2:0] ctrl, input logic [2:0] sh,
                       input logic [1:0] rd, input logic wr,
                       input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] eres);
    op_exp_t  o;
    res_exp_t r;
    in_valid = 1'b1; in_rs_addr = rs; in_rt_addr = rt;
    in_rs_data = rsd; in_rt_data = rtd; in_imm = imm; in_use_imm = ui;
    in_ALUcontrol = ctrl; in_shamt = sh; in_rd_addr = rd; in_wr_en = wr;
    o.a = ea; o.b = eb; o.ctrl = ctrl; o.sh = sh;
    r.res = eres; r.zero = (eres == 8'h00); r.rd = rd; r.wr = wr;
    op_q.push_back(o);
    res_q.push_back(r);
  endtask

  // Called just after a falling edge; returns one ns after the accepting edge
  task automatic wait_accept(output int n_stall);
    bit done = 1'b0;
    n_stall = 0;
    while (!done) begin
      #4;
      if (in_ready) begin
        @(posedge clock);
        #1 in_valid = 1'b0;
        done = 1'b1;
      end else if (n_stall >= 30) begin
        errors++; checks++;
        $display("FAIL accept_timeout: got %0d stall cycles expected acceptance", n_stall);
        in_valid = 1'b0;
        done = 1'b1;
      end else begin
        n_stall++;
        @(negedge clock);
      end
    end
  endtask

  task automatic issue(input logic [1:0] rs, input logic [1:0] rt,
                       input logic [7:0] rsd, input logic [7:0] rtd,
                       input logic [7:0] imm, input logic ui,
                       input logic [2:0] ctrl, input logic [2:0] sh,
                       input logic [1:0] rd, input logic wr,
                       input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] eres,
                       output int n_stall);
    @(negedge clock);
    offer(rs, rt, rsd, rtd, imm, ui, ctrl, sh, rd, wr, ea, eb, eres);
    wait_accept(n_stall);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: handshakes sampled just before the rising edge, operands just after
  initial begin
    bit acc, ohs;
    op_exp_t  o;
    res_exp_t r;
    forever begin
      @(negedge clock);
      #4;
      acc = in_valid && in_ready && !flush && !reset;
      ohs = out_valid && out_ready;
      if (ohs) begin
        if (res_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL result_unexpected: got 0x%0h expected no output", out_result);
        end else begin
          r = res_q.pop_front();
          chk("out_result", out_result, r.res);
          chk("out_zero", out_zero, r.zero);
          chk("out_rd_addr", out_rd_addr, r.rd);
          chk("out_wr_en", out_wr_en, r.wr);
        end
      end
      @(posedge clock);
      #1;
      if (acc) begin
        if (op_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL operand_unexpected: got a=0x%0h expected no capture", a);
        end else begin
          o = op_q.pop_front();
          chk("ex_a", a, o.a);
          chk("ex_b", b, o.b);
          chk("ex_ctrl", alu_ctrl, o.ctrl);
          chk("ex_shamt", shamt, o.sh);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    in_rs_addr = 2'd0; in_rt_addr = 2'd0; in_rd_addr = 2'd0; in_wr_en = 1'b0;
    in_rs_data = 8'h00; in_rt_data = 8'h00; in_imm = 8'h00; in_use_imm = 1'b0;
    in_ALUcontrol = 3'd0; in_shamt = 3'd0;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_a", a, 8'h00);
    chk("rst_b", b, 8'h00);
    chk("rst_ctrl_shamt", {alu_ctrl, shamt}, 6'h00);
    chk("rst_out_fields", {out_result, out_zero, out_rd_addr, out_wr_en}, 12'h000);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clock);
    reset = 1'b0;

    // single add with latency check; rd=0 treated as ordinary
    issue(2'd0, 2'd1, 8'h02, 8'h02, 8'h00, 1'b0, ALU_ADD, 3'd0, 2'd0, 1'b1, 8'h02, 8'h02, 8'h04, stalls);
    chk("lat_out_not_yet", out_valid, 1'b0);
    @(posedge clock); #1;
    chk("lat_out_valid", out_valid, 1'b1);
    chk("lat_out_result", out_result, 8'h04);
    cycles(3);

    // back-to-back dependency through rs
    issue(2'd0, 2'd3, 8'h05, 8'h03, 8'h00, 1'b0, ALU_ADD, 3'd0, 2'd1, 1'b1, 8'h05, 8'h03, 8'h08, stalls);
    issue(2'd1, 2'd2, FWD ? 8'h00 : 8'h08, 8'h01, 8'h00, 1'b0, ALU_ADD, 3'd0, 2'd2, 1'b0,
          8'h08, 8'h01, 8'h09, stalls);
    chk("dep_stalls", stalls, FWD ? 0 : 2);
    cycles(4);

    // both operands depend on register 0
    issue(2'd3, 2'd3, 8'h01, 8'h01, 8'h00, 1'b0, ALU_ADD, 3'd0, 2'd0, 1'b1, 8'h01, 8'h01, 8'h02, stalls);
    issue(2'd0, 2'd0, FWD ? 8'h00 : 8'h02, FWD ? 8'h00 : 8'h02, 8'h00, 1'b0, ALU_ADD, 3'd0, 2'd3, 1'b0,
          8'h02, 8'h02, 8'h04, stalls);
    chk("r0_stalls", stalls, FWD ? 0 : 2);
    cycles(4);

    // WB forward while out_ready=0 holds the producer in WB
    out_ready = 1'b0;
    issue(2'd0, 2'd0, 8'h08, 8'h08, 8'h00, 1'b0, ALU_ADD, 3'd0, 2'd2, 1'b1, 8'h08, 8'h08, 8'h10, stalls);
    cycles(1);
    @(negedge clock);
    offer(2'd2, 2'd1, FWD ? 8'h00 : 8'h10, 8'h01, 8'h00, 1'b0, ALU_ADD, 3'd0, 2'd3, 1'b0, 8'h10, 8'h01, 8'h11);
    if (FWD) begin
      wait_accept(stalls);
      chk("wbf_stalls", stalls, 0);
      chk("wbf_held_valid", out_valid, 1'b1);
      chk("wbf_held_result", out_result, 8'h10);
      @(negedge clock);
      out_ready = 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        #4 chk("wbf_hazard_ready", in_ready, 1'b0);
        @(negedge clock);
      end
      out_ready = 1'b1;
      wait_accept(stalls);
      chk("wbf_stalls", stalls, 1);
    end
    cycles(4);

    // backpressure: three offered, two captured, then in-order drain
    @(negedge clock);
    out_ready = 1'b0;
    issue(2'd1, 2'd2, 8'h07, 8'h07, 8'h00, 1'b0, ALU_SUB, 3'd0, 2'd1, 1'b0, 8'h07, 8'h07, 8'h00, stalls);
    issue(2'd0, 2'd3, 8'hF0, 8'h3C, 8'h00, 1'b0, ALU_AND, 3'd0, 2'd2, 1'b0, 8'hF0, 8'h3C, 8'h30, stalls);
    chk("bp_second_stalls", stalls, 0);
    @(negedge clock);
    offer(2'd3, 2'd0, 8'h0F, 8'h99, 8'hA0, 1'b1, ALU_OR, 3'd0, 2'd3, 1'b0, 8'h0F, 8'hA0, 8'hAF);
    for (int i = 0; i < 2; i++) begin
      #4 chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_hold_result", out_result, 8'h00);
      @(negedge clock);
    end
    out_ready = 1'b1;
    wait_accept(stalls);
    chk("bp_third_stalls", stalls, 0);
    issue(2'd2, 2'd1, 8'h03, 8'h55, 8'h00, 1'b0, ALU_SLL, 3'd2, 2'd0, 1'b0, 8'h03, 8'h55, 8'h0C, stalls);
    cycles(4);

    // flush with both stages full and an instruction on offer
    out_ready = 1'b0;
    issue(2'd0, 2'd1, 8'h11, 8'h22, 8'h00, 1'b0, ALU_ADD, 3'd0, 2'd1, 1'b0, 8'h11, 8'h22, 8'h33, stalls);
    issue(2'd2, 2'd3, 8'h01, 8'h02, 8'h00, 1'b0, ALU_ADD, 3'd0, 2'd0, 1'b0, 8'h01, 8'h02, 8'h03, stalls);
    @(negedge clock);
    in_valid = 1'b1; in_rs_data = 8'h77; in_rt_data = 8'h77; flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    res_q.delete();
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    cycles(3);
    chk("flush_ex_empty", out_valid, 1'b0);

    // async reset mid-cycle with both stages full
    out_ready = 1'b0;
    issue(2'd0, 2'd0, 8'h01, 8'h01, 8'h00, 1'b0, ALU_ADD, 3'd0, 2'd1, 1'b1, 8'h01, 8'h01, 8'h02, stalls);
    issue(2'd2, 2'd3, 8'h04, 8'h04, 8'h00, 1'b0, ALU_ADD, 3'd0, 2'd2, 1'b0, 8'h04, 8'h04, 8'h08, stalls);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_a", a, 8'h00);
    chk("arst_b", b, 8'h00);
    chk("arst_out_wr_en", out_wr_en, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    res_q.delete();
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    issue(2'd1, 2'd2, 8'h09, 8'h01, 8'h00, 1'b0, ALU_SUB, 3'd0, 2'd3, 1'b1, 8'h09, 8'h01, 8'h08, stalls);
    chk("post_rst_stalls", stalls, 0);
    cycles(4);

    chk("res_queue_empty", res_q.size(), 0);
    chk("op_queue_empty", op_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute-stage pipeline block of the nRISC 8-bit datapath, directly upstream and downstream of the ALU.
- Captures decoded operands, presents them to the ALU as registered a/b/ALUcontrol/shamt, then captures ALUout/zero into a writeback register.
- Provides valid/ready handshakes on both sides, plus EX-to-EX and WB-to-EX operand forwarding.

Parameters:
- DATA_W, 8, operand/result width
- REG_AW, 2, register address width
- CTRL_W, 3, ALUcontrol width
- SHAMT_W, 3, shift amount width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous kill of EX and WB contents
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_rs_addr, in_rt_addr  in  REG_AW  source register addresses
- in_rs_data, in_rt_data  in  DATA_W  register file read data
- in_imm  in  DATA_W  immediate
- in_use_imm  in  1  b := in_imm instead of rt
- in_ALUcontrol  in  CTRL_W  ALU operation
- in_shamt  in  SHAMT_W  shift amount
- in_rd_addr  in  REG_AW  destination
- in_wr_en  in  1  instruction writes rd
- ALUcontrol  out  CTRL_W  registered, to ALU
- a, b  out  DATA_W  registered operands, to ALU
- shamt  out  SHAMT_W  registered, to ALU
- ALUout  in  DATA_W  ALU result; combinational from a/b/ALUcontrol/shamt in the same cycle
- zero  in  1  ALU zero flag
- out_valid  out  1  WB register holds a result
- out_ready  in  1  writeback consumes
- out_result  out  DATA_W  captured ALUout
- out_zero  out  1  captured zero
- out_rd_addr  out  REG_AW  destination
- out_wr_en  out  1  write enable

Behaviour:
- Reset (async, active-high): ex_valid=0, out_valid=0; a, b, ALUcontrol, shamt, out_result, out_rd_addr = 0; out_zero=0; out_wr_en=0.
- Two registers:
  - EX: holds a, b, ALUcontrol, shamt, rd, wr_en, ex_valid.
  - WB: holds out_*.
- wb_adv = ex_valid && (!out_valid || out_ready).
- in_ready = !ex_valid || wb_adv. With FORWARDING_EN off, in_ready is additionally gated by the stall rule below.
- Accept = in_valid && in_ready. On accept, EX loads:
  - a = fwd(rs)
  - b = in_use_imm ? in_imm : fwd(rt)
  - control fields as given
- Forwarding fwd(x):
  - Priority 1: ex_valid && ex_wr_en && ex_rd==x → ALUout.
  - Priority 2: out_valid && out_wr_en && out_rd_addr==x → out_result.
  - Otherwise: register data.
  - Address 0 is treated like any other register.
- On wb_adv: WB loads ALUout, zero, ex_rd, ex_wr_en, and out_valid=1.
- If out_valid && out_ready && !wb_adv: out_valid=0.
- ex_valid next = accept ? 1 : (wb_adv ? 0 : ex_valid).
- Latency: accepted at edge N, operands on a/b after N; result on out_* after edge N+1 if WB is free. Sustained throughput is 1/cycle with out_ready=1.
- Backpressure: with out_ready=0 and both stages full, in_ready=0. EX and WB hold all values stable.
- flush: at the next edge, ex_valid=0 and out_valid=0; no accept occurs. Flush wins over simultaneous accept and wb_adv. Data registers may keep stale values.
- Reset mid-operation: all valids drop immediately (async); in-flight instructions are lost.
- Simultaneous accept + wb_adv: legal. The old EX moves to WB while the new instruction enters EX in the same edge.

Optional Feature:
- Macro: EX_FORWARDING_EN.
- Defined: forwarding as above.
- Undefined: no forwarding mux; operands always come from register data.
  - Hazard: (rs, or rt with !in_use_imm) matches a valid writing EX or WB rd.
  - On hazard, in_ready=0 until the conflicting instruction leaves WB.

Decomposition:
- Shared package nrisc_pkg:
  - DATA_W, REG_AW, CTRL_W, SHAMT_W constants.
  - alu_ctrl_t (3-bit) and the ALU operation code localparams.
  - ex_bundle_t struct for the EX register contents.
- One sub-module, ex_fwd_mux: combinational source selection for one operand, instantiated twice.

Test Plan:
- Single op: rs_data=0x02, rt_data=0x02, ALUcontrol=0, bench ALU model=add → a=b=0x02 one cycle later; out_result=0x04, out_zero=0, out_valid=1 the following cycle.
- Back-to-back dependency: I1 rd=1 (0x05+0x03); I2 rs=1, rt_data=0x01 next cycle → I2 a=0x08 (EX forward), result 0x09. With EX_FORWARDING_EN off: in_ready=0 for 2 cycles, then a=0x08 from register data.
- WB forward: I1 rd=2 → result 0x10; bubble; I3 rs=2 → a=0x10 from out_result, while out_ready=0 holds I1 in WB.
- Backpressure: out_ready=0 with 3 instructions offered → two captured, in_ready=0; out_ready=1 → results drain in order, no loss or duplication.
- Flush with in_valid=1 and both stages full → next cycle ex_valid=0, out_valid=0; the offered instruction is not captured.
- Async reset asserted mid-cycle with both stages full → out_valid=0 and a=b=0 immediately, before the next edge.
